// File: rtl/alarm_time_setter.sv
// ---------------------------------------------------------------------------
// alarm_time_setter
//
// Button-driven editor that writes a 12-hour BCD time word into the
// alarm/time register. Mode steps IDLE -> HOUR -> MIN -> COMMIT -> IDLE.
// Inc advances the hour in HOUR and the minute in MIN. COMMIT lasts one
// cycle and pulses Enable so that the downstream register loads D.
// An edit state with no button activity for TIMEOUT cycles drops back to
// IDLE without loading the register.
//
// Ports:
//   Clock    in   system clock, rising edge
//   Clear    in   asynchronous active-high reset
//   Mode     in   debounced level; rising edge advances the FSM
//   Inc      in   debounced level; rising edge advances the selected field
//   D        out  [12:0] working time word {PM, Htens, Hunits[3:0],
//                 Mtens[2:0], Munits[3:0]}
//   Enable   out  one-cycle load strobe (high only in COMMIT)
//   Editing  out  high while in HOUR or MIN
//   Field    out  [1:0] 00 idle, 01 hour, 10 minute, 11 commit
// ---------------------------------------------------------------------------
module alarm_time_setter #(
    parameter int TIMEOUT = 1000,
    parameter int TW      = 10
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        Mode,
    input  logic        Inc,
    output logic [12:0] D,
    output logic        Enable,
    output logic        Editing,
    output logic [1:0]  Field
);

    // State encoding doubles as the Field output code.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HOUR   = 2'b01,
        MIN    = 2'b10,
        COMMIT = 2'b11
    } state_e;

    localparam logic [12:0] RESET_TIME = 13'h0900;  // 12:00 AM

    state_e        state_q;
    logic          mode_prev_q;
    logic          inc_prev_q;
    logic [12:0]   time_q;
    logic          enable_q;
    logic          editing_q;
    logic [TW-1:0] tmo_q;

    logic          mode_edge;
    logic          inc_edge;
    logic          tmo_hit;
    logic [12:0]   hour_next;
    logic [12:0]   min_next;

    // Previous-value registers reset to 1, so a button held through reset
    // does not produce an edge when Clear drops.
    assign mode_edge = Mode & ~mode_prev_q;
    assign inc_edge  = Inc  & ~inc_prev_q;
    assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // Hour step: 1..9 in units, 9->10, 10->11, 11->12 toggles PM,
    // 12->1 keeps PM.
    // ------------------------------------------------------------------
    always_comb begin
        logic       pm;
        logic       ht;
        logic [3:0] hu;
        pm = time_q[12];
        ht = time_q[11];
        hu = time_q[10:7];
        if (!ht && hu == 4'd9) begin
            ht = 1'b1;
            hu = 4'd0;
        end else if (ht && hu == 4'd1) begin
            hu = 4'd2;
            pm = ~pm;
        end else if (ht && hu == 4'd2) begin
            ht = 1'b0;
            hu = 4'd1;
        end else begin
            hu = hu + 4'd1;
        end
        hour_next = {pm, ht, hu, time_q[6:0]};
    end

    // ------------------------------------------------------------------
    // Minute step: units 9 carries into tens, 59 wraps to 00 with no
    // carry into the hour.
    // ------------------------------------------------------------------
    always_comb begin
        logic [2:0] mt;
        logic [3:0] mu;
        mt = time_q[6:4];
        mu = time_q[3:0];
        if (mu == 4'd9) begin
            mu = 4'd0;
            mt = (mt == 3'd5) ? 3'd0 : mt + 3'd1;
        end else begin
            mu = mu + 4'd1;
        end
        min_next = {time_q[12:7], mt, mu};
    end

    // ------------------------------------------------------------------
    // FSM with registered outputs. Mode is tested before Inc in every
    // edit state, so a simultaneous press discards the Inc.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q     <= IDLE;
            mode_prev_q <= 1'b1;
            inc_prev_q  <= 1'b1;
            time_q      <= RESET_TIME;
            enable_q    <= 1'b0;
            editing_q   <= 1'b0;
            tmo_q       <= '0;
        end else begin
            mode_prev_q <= Mode;
            inc_prev_q  <= Inc;
            enable_q    <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (mode_edge) begin
                        state_q   <= HOUR;
                        editing_q <= 1'b1;
                        tmo_q     <= '0;
                    end
                end

                HOUR: begin
                    if (mode_edge) begin
                        state_q <= MIN;
                        tmo_q   <= '0;
                    end else if (inc_edge) begin
                        time_q <= hour_next;
                        tmo_q  <= '0;
                    end else if (tmo_hit) begin
                        // Abandon the edit; time_q keeps what was entered.
                        state_q   <= IDLE;
                        editing_q <= 1'b0;
                        tmo_q     <= '0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                MIN: begin
                    if (mode_edge) begin
                        state_q   <= COMMIT;
                        editing_q <= 1'b0;
                        enable_q  <= 1'b1;
                        tmo_q     <= '0;
                    end else if (inc_edge) begin
                        time_q <= min_next;
                        tmo_q  <= '0;
                    end else if (tmo_hit) begin
                        state_q   <= IDLE;
                        editing_q <= 1'b0;
                        tmo_q     <= '0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                // Single-cycle load; enable_q was set on entry and falls
                // here by the default above.
                COMMIT: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q   <= IDLE;
                    editing_q <= 1'b0;
                end
            endcase
        end
    end

    assign D       = time_q;
    assign Enable  = enable_q;
    assign Editing = editing_q;
    assign Field   = state_q;

endmodule

// File: tb/tb_alarm_time_setter.sv
// ---------------------------------------------------------------------------
// Directed bench for alarm_time_setter. Inputs change on the falling edge;
// outputs are sampled on the falling edge after the rising edge that acted.
// ---------------------------------------------------------------------------
module tb_alarm_time_setter;
    localparam int TIMEOUT = 1000;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        Mode  = 1'b1;
    logic        Inc   = 1'b1;
    logic [12:0] D;
    logic        Enable;
    logic        Editing;
    logic [1:0]  Field;

    int total = 0;
    int bad   = 0;

    // Downstream register model and Enable monitors.
    logic [12:0] ref_q = 13'h0000;
    int          en_count  = 0;
    int          en_double = 0;
    logic        en_prev   = 1'b0;

    alarm_time_setter #(.TIMEOUT(TIMEOUT), .TW(10)) dut (
        .Clock   (Clock),
        .Clear   (Clear),
        .Mode    (Mode),
        .Inc     (Inc),
        .D       (D),
        .Enable  (Enable),
        .Editing (Editing),
        .Field   (Field)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) if (Enable) ref_q <= D;

    always @(negedge Clock) begin
        if (Enable) en_count++;
        if (Enable && en_prev) en_double++;
        en_prev = Enable;
    end

    task automatic press_mode();
        @(negedge Clock); Mode = 1'b1;
        @(negedge Clock); Mode = 1'b0;
    endtask

    task automatic press_inc();
        @(negedge Clock); Inc = 1'b1;
        @(negedge Clock); Inc = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge Clock); Clear = 1'b1;
        @(negedge Clock); Clear = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge Clock);
        Clear = 1'b0;
        #1;
        total++; if (D !== 13'h0900) begin bad++; $display("FAIL reset_D got=%h want=%h", D, 13'h0900); end
        total++; if (Enable !== 1'b0) begin bad++; $display("FAIL reset_Enable got=%b want=0", Enable); end
        total++; if (Field !== 2'b00) begin bad++; $display("FAIL reset_Field got=%b want=00", Field); end
        total++; if (Editing !== 1'b0) begin bad++; $display("FAIL reset_Editing got=%b want=0", Editing); end
        // Buttons still held: no edge may be seen.
        repeat (3) @(negedge Clock);
        total++; if (Field !== 2'b00) begin bad++; $display("FAIL reset_held_Field got=%b want=00", Field); end
        Mode = 1'b0; Inc = 1'b0;
        @(negedge Clock);
    endtask

    task automatic test_idle_inc();
        press_inc();
        total++; if (Field !== 2'b00) begin bad++; $display("FAIL idle_inc_Field got=%b want=00", Field); end
        total++; if (D !== 13'h0900) begin bad++; $display("FAIL idle_inc_D got=%h want=%h", D, 13'h0900); end
    endtask

    task automatic test_hour_wrap();
        logic [12:0] exp;
        press_mode();
        total++; if (Field !== 2'b01) begin bad++; $display("FAIL hour_entry_Field got=%b want=01", Field); end
        total++; if (Editing !== 1'b1) begin bad++; $display("FAIL hour_entry_Editing got=%b want=1", Editing); end
        for (int i = 1; i <= 13; i++) begin
            press_inc();
            // 12AM -> 1AM ... 9AM, 10AM, 11AM, 12PM, 1PM
            case (i)
                1:  exp = 13'h0080;
                9:  exp = 13'h0480;
                10: exp = 13'h0800;
                11: exp = 13'h0880;
                12: exp = 13'h1900;
                13: exp = 13'h1080;
                default: exp = 13'h0000;
            endcase
            if (i == 1 || i >= 9) begin
                total++;
                if (D !== exp) begin bad++; $display("FAIL hour_step%0d got=%h want=%h", i, D, exp); end
            end
        end
        total++; if (Field !== 2'b01) begin bad++; $display("FAIL hour_stay_Field got=%b want=01", Field); end
    endtask

    task automatic test_minute_wrap();
        logic [12:0] exp;
        pulse_clear();
        press_mode();
        press_mode();
        total++; if (Field !== 2'b10) begin bad++; $display("FAIL min_entry_Field got=%b want=10", Field); end
        for (int i = 1; i <= 60; i++) begin
            press_inc();
            case (i)
                9:  exp = 13'h0909;
                10: exp = 13'h0910;
                59: exp = 13'h0959;
                60: exp = 13'h0900;
                default: exp = 13'h0000;
            endcase
            if (i == 9 || i == 10 || i >= 59) begin
                total++;
                if (D !== exp) begin bad++; $display("FAIL min_step%0d got=%h want=%h", i, D, exp); end
            end
        end
        total++; if (Enable !== 1'b0) begin bad++; $display("FAIL min_Enable got=%b want=0", Enable); end
        pulse_clear();
    endtask

    task automatic test_commit();
        press_mode();
        press_inc();        // 1 AM
        press_mode();
        repeat (3) press_inc();  // 1:03 AM
        total++; if (D !== 13'h0083) begin bad++; $display("FAIL commit_pre_D got=%h want=%h", D, 13'h0083); end
        en_count = 0;
        en_double = 0;
        press_mode();
        total++; if (Enable !== 1'b1) begin bad++; $display("FAIL commit_Enable got=%b want=1", Enable); end
        total++; if (Field !== 2'b11) begin bad++; $display("FAIL commit_Field got=%b want=11", Field); end
        total++; if (Editing !== 1'b0) begin bad++; $display("FAIL commit_Editing got=%b want=0", Editing); end
        total++; if (D !== 13'h0083) begin bad++; $display("FAIL commit_D got=%h want=%h", D, 13'h0083); end
        @(negedge Clock);
        total++; if (Enable !== 1'b0) begin bad++; $display("FAIL commit_after_Enable got=%b want=0", Enable); end
        total++; if (Field !== 2'b00) begin bad++; $display("FAIL commit_after_Field got=%b want=00", Field); end
        total++; if (ref_q !== 13'h0083) begin bad++; $display("FAIL commit_regQ got=%h want=%h", ref_q, 13'h0083); end
        repeat (3) @(negedge Clock);
        total++; if (en_count !== 1) begin bad++; $display("FAIL commit_en_count got=%0d want=1", en_count); end
        total++; if (en_double !== 0) begin bad++; $display("FAIL commit_en_double got=%0d want=0", en_double); end
    endtask

    task automatic test_timeout();
        pulse_clear();
        press_mode();
        press_inc();
        total++; if (D !== 13'h0080) begin bad++; $display("FAIL tmo_inc_D got=%h want=%h", D, 13'h0080); end
        en_count = 0;
        repeat (TIMEOUT - 1) @(negedge Clock);
        total++; if (Field !== 2'b01) begin bad++; $display("FAIL tmo_early_Field got=%b want=01", Field); end
        @(negedge Clock);
        total++; if (Field !== 2'b00) begin bad++; $display("FAIL tmo_Field got=%b want=00", Field); end
        total++; if (Editing !== 1'b0) begin bad++; $display("FAIL tmo_Editing got=%b want=0", Editing); end
        total++; if (D !== 13'h0080) begin bad++; $display("FAIL tmo_D got=%h want=%h", D, 13'h0080); end
        total++; if (en_count !== 0) begin bad++; $display("FAIL tmo_en_count got=%0d want=0", en_count); end
        total++; if (ref_q !== 13'h0083) begin bad++; $display("FAIL tmo_regQ got=%h want=%h", ref_q, 13'h0083); end
    endtask

    task automatic test_persist_hold();
        press_mode();
        total++; if (D !== 13'h0080) begin bad++; $display("FAIL persist_D got=%h want=%h", D, 13'h0080); end
        // Held button acts once.
        @(negedge Clock); Inc = 1'b1;
        repeat (5) @(negedge Clock);
        Inc = 1'b0;
        @(negedge Clock);
        total++; if (D !== 13'h0100) begin bad++; $display("FAIL hold_D got=%h want=%h", D, 13'h0100); end
    endtask

    task automatic test_collision();
        en_count = 0;
        @(negedge Clock); Mode = 1'b1; Inc = 1'b1;
        @(negedge Clock); Mode = 1'b0; Inc = 1'b0;
        total++; if (Field !== 2'b10) begin bad++; $display("FAIL coll_Field got=%b want=10", Field); end
        total++; if (D !== 13'h0100) begin bad++; $display("FAIL coll_D got=%h want=%h", D, 13'h0100); end
        press_inc();
        total++; if (D !== 13'h0101) begin bad++; $display("FAIL coll_min_D got=%h want=%h", D, 13'h0101); end
        // Clear between clock edges must act without a clock.
        @(negedge Clock); #2 Clear = 1'b1;
        #1;
        total++; if (Field !== 2'b00) begin bad++; $display("FAIL clr_Field got=%b want=00", Field); end
        total++; if (D !== 13'h0900) begin bad++; $display("FAIL clr_D got=%h want=%h", D, 13'h0900); end
        total++; if (Editing !== 1'b0) begin bad++; $display("FAIL clr_Editing got=%b want=0", Editing); end
        @(negedge Clock); Clear = 1'b0;
        repeat (2) @(negedge Clock);
        total++; if (en_count !== 0) begin bad++; $display("FAIL clr_en_count got=%0d want=0", en_count); end
        total++; if (Field !== 2'b00) begin bad++; $display("FAIL clr_after_Field got=%b want=00", Field); end
    endtask

    initial begin
        test_reset();
        test_idle_inc();
        test_hour_wrap();
        test_minute_wrap();
        test_commit();
        test_timeout();
        test_persist_hold();
        test_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
